// File: rtl/uart_cfg_regfile_fifo_if.sv
// User register bus for uart_cfg_regfile_fifo: access strobe, direction,
// address, write data and the registered read-data return path.
interface uart_cfg_regfile_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              usr_ctrl_vld;
    logic              usr_ctrl_wnr;
    logic [ADDR_W-1:0] usr_data_addr;
    logic [DATA_W-1:0] usr_data_cfgdata;
    logic [DATA_W-1:0] usr_data_rdata;

    modport master (
        output usr_ctrl_vld, usr_ctrl_wnr, usr_data_addr, usr_data_cfgdata,
        input  usr_data_rdata
    );

    modport slave (
        input  usr_ctrl_vld, usr_ctrl_wnr, usr_data_addr, usr_data_cfgdata,
        output usr_data_rdata
    );
endinterface

// File: rtl/uart_cfg_regfile_fifo.sv
// UART configuration register file with Tx/Rx byte FIFOs, sticky overflow flags
// and level readback. Optional Rx-threshold/overflow interrupt: UART_CFG_IRQ_EN.
module uart_cfg_regfile_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3,
    parameter int ADDR_W  = 5
) (
    input  logic                      glb_clk,
    input  logic                      glb_rst,
    uart_cfg_regfile_fifo_if.slave    usr,
    input  logic                      PROT_CFG_ctrl_tx_r_en,
    input  logic                      PROT_CFG_ctrl_tx_rst,
    input  logic                      PROT_CFG_ctrl_rx_w_en,
    input  logic                      PROT_CFG_ctrl_rx_rst,
    input  logic [DATA_W-1:0]         PROT_CFG_data_rx_data,
    output logic [DATA_W-1:0]         CFG_SEL_data_tx_data,
    output logic                      Tx_FIFO_full,
    output logic                      Tx_FIFO_empty,
    output logic                      Rx_FIFO_full,
    output logic                      Rx_FIFO_empty,
    output logic [1:0]                parity_cfg,
    output logic                      stop_cfg,
    output logic                      CFG_PROT_ctrl_Txen,
    output logic                      CFG_PROT_ctrl_Rxen,
    output logic [DATA_W-1:0]         slave_addr,
    output logic [DATA_W-1:0]         self_addr,
    output logic [DATA_W-1:0]         stop_frame,
    output logic [DATA_W-1:0]         baud_cmp,
    output logic                      CFG_irq
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam logic [PW-1:0] FULL_XOR = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SLAVE   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_SELF    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STOPF   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_BAUD    = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_TXDATA  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_RXDATA  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_TXLVL   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_RXLVL   = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] A_IRQCFG  = ADDR_W'(10);

    logic [4:0]        r_ctrl;
    logic [DATA_W-1:0] r_slave, r_self, r_stopf, r_baud, r_rdata;
    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [PW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic              r_tx_ovf, r_rx_ovf;

    logic              w_wr, w_rd, w_ctrl_wr, w_status_rd;
    logic              w_tx_flush, w_tx_push, w_tx_pop, w_tx_push_ok, w_tx_ovf_set;
    logic              w_rx_flush, w_rx_push, w_rx_pop, w_rx_push_ok, w_rx_ovf_set;
    logic [PW-1:0]     w_tx_wp_nxt, w_tx_rp_nxt, w_rx_wp_nxt, w_rx_rp_nxt;
    logic [PW-1:0]     w_tx_level, w_rx_level;
    logic              w_tx_ovf_nxt, w_rx_ovf_nxt;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_wr        = usr.usr_ctrl_vld &  usr.usr_ctrl_wnr;
    assign w_rd        = usr.usr_ctrl_vld & ~usr.usr_ctrl_wnr;
    assign w_ctrl_wr   = w_wr & (usr.usr_data_addr == A_CTRL);
    assign w_status_rd = w_rd & (usr.usr_data_addr == A_STATUS);

    assign Tx_FIFO_empty = (r_tx_wp == r_tx_rp);
    assign Tx_FIFO_full  = ((r_tx_wp ^ r_tx_rp) == FULL_XOR);
    assign Rx_FIFO_empty = (r_rx_wp == r_rx_rp);
    assign Rx_FIFO_full  = ((r_rx_wp ^ r_rx_rp) == FULL_XOR);
    assign w_tx_level    = r_tx_wp - r_tx_rp;
    assign w_rx_level    = r_rx_wp - r_rx_rp;

    assign w_tx_flush = PROT_CFG_ctrl_tx_rst | (w_ctrl_wr & usr.usr_data_cfgdata[5]);
    assign w_rx_flush = PROT_CFG_ctrl_rx_rst | (w_ctrl_wr & usr.usr_data_cfgdata[6]);
    assign w_tx_push  = w_wr & (usr.usr_data_addr == A_TXDATA);
    assign w_tx_pop   = PROT_CFG_ctrl_tx_r_en & ~Tx_FIFO_empty;
    assign w_rx_push  = PROT_CFG_ctrl_rx_w_en;
    assign w_rx_pop   = w_rd & (usr.usr_data_addr == A_RXDATA) & ~Rx_FIFO_empty;

    // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
    assign w_tx_push_ok = w_tx_push & (~Tx_FIFO_full | w_tx_pop);
    assign w_rx_push_ok = w_rx_push & (~Rx_FIFO_full | w_rx_pop);
    assign w_tx_ovf_set = w_tx_push & Tx_FIFO_full & ~w_tx_pop;
    assign w_rx_ovf_set = w_rx_push & Rx_FIFO_full & ~w_rx_pop;
    assign w_tx_ovf_nxt = w_tx_ovf_set | (r_tx_ovf & ~w_status_rd);
    assign w_rx_ovf_nxt = w_rx_ovf_set | (r_rx_ovf & ~w_status_rd);

    always_comb begin
        w_tx_wp_nxt = r_tx_wp;
        w_tx_rp_nxt = r_tx_rp;
        w_rx_wp_nxt = r_rx_wp;
        w_rx_rp_nxt = r_rx_rp;
        if (w_tx_flush) begin
            w_tx_wp_nxt = '0;
            w_tx_rp_nxt = '0;
        end else begin
            if (w_tx_push_ok) w_tx_wp_nxt = r_tx_wp + PW'(1);
            if (w_tx_pop)     w_tx_rp_nxt = r_tx_rp + PW'(1);
        end
        if (w_rx_flush) begin
            w_rx_wp_nxt = '0;
            w_rx_rp_nxt = '0;
        end else begin
            if (w_rx_push_ok) w_rx_wp_nxt = r_rx_wp + PW'(1);
            if (w_rx_pop)     w_rx_rp_nxt = r_rx_rp + PW'(1);
        end
    end

`ifdef UART_CFG_IRQ_EN
    logic [DATA_W-1:0] r_irq_cfg, w_irq_cfg_nxt;
    logic              r_irq, w_irq_nxt;
    logic [PW-1:0]     w_thr, w_rx_level_nxt;

    assign w_rx_level_nxt = w_rx_wp_nxt - w_rx_rp_nxt;

    // Evaluated on next-state values so CFG_irq lines up with the new level.
    always_comb begin
        w_irq_cfg_nxt = r_irq_cfg;
        if (w_wr && (usr.usr_data_addr == A_IRQCFG)) w_irq_cfg_nxt = usr.usr_data_cfgdata;
        w_thr     = w_irq_cfg_nxt[FIFO_AW:0];
        w_irq_nxt = ((w_thr != '0) && (w_rx_level_nxt >= w_thr))
                  || (w_irq_cfg_nxt[7] && (w_tx_ovf_nxt || w_rx_ovf_nxt));
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            r_irq_cfg <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_irq_cfg <= w_irq_cfg_nxt;
            r_irq     <= w_irq_nxt;
        end
    end

    assign CFG_irq = r_irq;
`else
    assign CFG_irq = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (usr.usr_data_addr)
            A_CTRL:   w_rd_mux = DATA_W'(r_ctrl);
            A_STATUS: w_rd_mux = DATA_W'({r_tx_ovf, r_rx_ovf, Tx_FIFO_full, Tx_FIFO_empty,
                                          Rx_FIFO_full, Rx_FIFO_empty});
            A_SLAVE:  w_rd_mux = r_slave;
            A_SELF:   w_rd_mux = r_self;
            A_STOPF:  w_rd_mux = r_stopf;
            A_BAUD:   w_rd_mux = r_baud;
            A_RXDATA: w_rd_mux = r_rx_mem[r_rx_rp[FIFO_AW-1:0]];
            A_TXLVL:  w_rd_mux = DATA_W'(w_tx_level);
            A_RXLVL:  w_rd_mux = DATA_W'(w_rx_level);
`ifdef UART_CFG_IRQ_EN
            A_IRQCFG: w_rd_mux = r_irq_cfg;
`endif
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            r_ctrl   <= '0;
            r_slave  <= '0;
            r_self   <= '0;
            r_stopf  <= '0;
            r_baud   <= '0;
            r_rdata  <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                case (usr.usr_data_addr)
                    A_CTRL:  r_ctrl  <= usr.usr_data_cfgdata[4:0];
                    A_SLAVE: r_slave <= usr.usr_data_cfgdata;
                    A_SELF:  r_self  <= usr.usr_data_cfgdata;
                    A_STOPF: r_stopf <= usr.usr_data_cfgdata;
                    A_BAUD:  r_baud  <= usr.usr_data_cfgdata;
                    default: ;
                endcase
            end
            if (w_rd) r_rdata <= w_rd_mux;
            r_tx_wp  <= w_tx_wp_nxt;
            r_tx_rp  <= w_tx_rp_nxt;
            r_rx_wp  <= w_rx_wp_nxt;
            r_rx_rp  <= w_rx_rp_nxt;
            r_tx_ovf <= w_tx_ovf_nxt;
            r_rx_ovf <= w_rx_ovf_nxt;
        end
    end

    always_ff @(posedge glb_clk) begin
        if (!glb_rst && w_tx_push_ok) r_tx_mem[r_tx_wp[FIFO_AW-1:0]] <= usr.usr_data_cfgdata;
        if (!glb_rst && w_rx_push_ok) r_rx_mem[r_rx_wp[FIFO_AW-1:0]] <= PROT_CFG_data_rx_data;
    end

    assign usr.usr_data_rdata   = r_rdata;
    assign CFG_SEL_data_tx_data = r_tx_mem[r_tx_rp[FIFO_AW-1:0]];
    assign CFG_PROT_ctrl_Txen   = r_ctrl[0];
    assign CFG_PROT_ctrl_Rxen   = r_ctrl[1];
    assign parity_cfg           = r_ctrl[3:2];
    assign stop_cfg             = r_ctrl[4];
    assign slave_addr           = r_slave;
    assign self_addr            = r_self;
    assign stop_frame           = r_stopf;
    assign baud_cmp             = r_baud;
endmodule

// File: tb/tb_uart_cfg_regfile_fifo.sv
// Scoreboard bench for uart_cfg_regfile_fifo: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_uart_cfg_regfile_fifo;
    localparam int DEPTH = 8;
`ifdef UART_CFG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cfg_regfile_fifo_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    logic       tx_r_en = 0, tx_rst = 0, rx_w_en = 0, rx_rst = 0;
    logic [7:0] rx_data = '0;
    logic [7:0] tx_head, slave_addr, self_addr, stop_frame, baud_cmp;
    logic       txf, txe, rxf, rxe, stop_cfg, txen, rxen, irq;
    logic [1:0] parity_cfg;

    uart_cfg_regfile_fifo #(.DATA_W(8), .FIFO_AW(3), .ADDR_W(5)) dut (
        .glb_clk(clk), .glb_rst(rst), .usr(bus),
        .PROT_CFG_ctrl_tx_r_en(tx_r_en), .PROT_CFG_ctrl_tx_rst(tx_rst),
        .PROT_CFG_ctrl_rx_w_en(rx_w_en), .PROT_CFG_ctrl_rx_rst(rx_rst),
        .PROT_CFG_data_rx_data(rx_data), .CFG_SEL_data_tx_data(tx_head),
        .Tx_FIFO_full(txf), .Tx_FIFO_empty(txe), .Rx_FIFO_full(rxf), .Rx_FIFO_empty(rxe),
        .parity_cfg(parity_cfg), .stop_cfg(stop_cfg),
        .CFG_PROT_ctrl_Txen(txen), .CFG_PROT_ctrl_Rxen(rxen),
        .slave_addr(slave_addr), .self_addr(self_addr), .stop_frame(stop_frame),
        .baud_cmp(baud_cmp), .CFG_irq(irq)
    );

    typedef struct {
        logic rst, vld, wnr;
        logic [4:0] addr;
        logic [7:0] wd;
        logic tx_pop, tx_rst, rx_push, rx_rst;
        logic [7:0] rxd;
    } stim_t;

    typedef struct {
        logic txen, rxen, stop, txe, txf, rxe, rxf, head_vld, irq;
        logic [1:0] par;
        logic [7:0] slave, self_a, stopf, baud, head, rdata;
    } exp_t;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } rd_exp_t;

    int checks = 0;
    int errors = 0;
    exp_t    st_q[$];
    rd_exp_t rd_q[$];

    // Reference model state
    logic       m_txen = 0, m_rxen = 0, m_stop = 0, m_txovf = 0, m_rxovf = 0;
    logic [1:0] m_par = '0;
    logic [7:0] m_slave = '0, m_self = '0, m_stopf = '0, m_baud = '0, m_irqcfg = '0, m_rdata = '0;
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:  return {3'b000, m_stop, m_par, m_rxen, m_txen};
            5'd1:  return {2'b00, m_txovf, m_rxovf, m_tx.size() == DEPTH, m_tx.size() == 0,
                           m_rx.size() == DEPTH, m_rx.size() == 0};
            5'd2:  return m_slave;
            5'd3:  return m_self;
            5'd4:  return m_stopf;
            5'd5:  return m_baud;
            5'd7:  return (m_rx.size() > 0) ? m_rx[0] : 8'h00;
            5'd8:  return 8'(m_tx.size());
            5'd9:  return 8'(m_rx.size());
            5'd10: return IRQ_EN ? m_irqcfg : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_step(input stim_t s);
        bit wr, rd, st_rd, tx_popped, rx_popped, tx_ov, rx_ov;
        if (s.rst) begin
            {m_txen, m_rxen, m_stop, m_txovf, m_rxovf} = '0;
            m_par = '0; m_slave = '0; m_self = '0; m_stopf = '0; m_baud = '0;
            m_irqcfg = '0; m_rdata = '0;
            m_tx.delete(); m_rx.delete();
            return;
        end
        wr    = s.vld && s.wnr;
        rd    = s.vld && !s.wnr;
        st_rd = rd && s.addr == 5'd1;
        if (rd) m_rdata = m_read(s.addr);

        tx_popped = s.tx_pop && m_tx.size() > 0;
        tx_ov     = wr && s.addr == 5'd6 && m_tx.size() == DEPTH && !tx_popped;
        if (s.tx_rst || (wr && s.addr == 5'd0 && s.wd[5])) m_tx.delete();
        else begin
            if (tx_popped) void'(m_tx.pop_front());
            if (wr && s.addr == 5'd6 && !tx_ov) m_tx.push_back(s.wd);
        end
        m_txovf = tx_ov || (m_txovf && !st_rd);

        rx_popped = rd && s.addr == 5'd7 && m_rx.size() > 0;
        rx_ov     = s.rx_push && m_rx.size() == DEPTH && !rx_popped;
        if (s.rx_rst || (wr && s.addr == 5'd0 && s.wd[6])) m_rx.delete();
        else begin
            if (rx_popped) void'(m_rx.pop_front());
            if (s.rx_push && !rx_ov) m_rx.push_back(s.rxd);
        end
        m_rxovf = rx_ov || (m_rxovf && !st_rd);

        if (wr) begin
            case (s.addr)
                5'd0: begin m_txen = s.wd[0]; m_rxen = s.wd[1]; m_par = s.wd[3:2]; m_stop = s.wd[4]; end
                5'd2: m_slave = s.wd;
                5'd3: m_self  = s.wd;
                5'd4: m_stopf = s.wd;
                5'd5: m_baud  = s.wd;
                5'd10: if (IRQ_EN) m_irqcfg = s.wd;
                default: ;
            endcase
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int   thr;
        thr = int'(m_irqcfg[3:0]);
        e.txen = m_txen; e.rxen = m_rxen; e.stop = m_stop; e.par = m_par;
        e.slave = m_slave; e.self_a = m_self; e.stopf = m_stopf; e.baud = m_baud;
        e.txe = (m_tx.size() == 0); e.txf = (m_tx.size() == DEPTH);
        e.rxe = (m_rx.size() == 0); e.rxf = (m_rx.size() == DEPTH);
        e.head_vld = (m_tx.size() > 0);
        e.head = e.head_vld ? m_tx[0] : 8'h00;
        e.irq = IRQ_EN && ((thr != 0 && m_rx.size() >= thr) || (m_irqcfg[7] && (m_txovf || m_rxovf)));
        e.rdata = m_rdata;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, vld: 1'b0, wnr: 1'b0, addr: 5'd0, wd: 8'h00,
              tx_pop: 1'b0, tx_rst: 1'b0, rx_push: 1'b0, rx_rst: 1'b0, rxd: 8'h00};
        return s;
    endfunction

    // Drive one cycle, queue expectations, return at posedge+2.
    task automatic cyc(input stim_t s, input bit use_c = 0, input logic [7:0] c = 8'h00,
                       input string nm = "rdata");
        @(negedge clk);
        rst = s.rst;
        bus.usr_ctrl_vld = s.vld; bus.usr_ctrl_wnr = s.wnr;
        bus.usr_data_addr = s.addr; bus.usr_data_cfgdata = s.wd;
        tx_r_en = s.tx_pop; tx_rst = s.tx_rst; rx_w_en = s.rx_push; rx_rst = s.rx_rst;
        rx_data = s.rxd;
        if (!s.rst && s.vld && !s.wnr) rd_q.push_back('{nm, use_c ? c : m_read(s.addr)});
        m_step(s);
        st_q.push_back(m_expect());
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic pop = 0,
                      input logic trst = 0);
        stim_t s = idle();
        s.vld = 1; s.wnr = 1; s.addr = a; s.wd = d; s.tx_pop = pop; s.tx_rst = trst;
        cyc(s);
    endtask

    task automatic rd_exp(input logic [4:0] a, input logic [7:0] e, input string nm);
        stim_t s = idle();
        s.vld = 1; s.addr = a;
        cyc(s, 1, e, nm);
    endtask

    // Monitor
    initial begin
        exp_t    e;
        rd_exp_t r;
        bit      was_rd;
        forever begin
            @(posedge clk);
            was_rd = bus.usr_ctrl_vld && !bus.usr_ctrl_wnr && !rst;
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("txen", txen, e.txen);
                chk("rxen", rxen, e.rxen);
                chk("parity_cfg", parity_cfg, e.par);
                chk("stop_cfg", stop_cfg, e.stop);
                chk("slave_addr", slave_addr, e.slave);
                chk("self_addr", self_addr, e.self_a);
                chk("stop_frame", stop_frame, e.stopf);
                chk("baud_cmp", baud_cmp, e.baud);
                chk("tx_empty", txe, e.txe);
                chk("tx_full", txf, e.txf);
                chk("rx_empty", rxe, e.rxe);
                chk("rx_full", rxf, e.rxf);
                chk("cfg_irq", irq, e.irq);
                chk("rdata_hold", bus.usr_data_rdata, e.rdata);
                if (e.head_vld) chk("tx_head", tx_head, e.head);
            end
            if (was_rd) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_scoreboard: got read with no expectation queued");
                end else begin
                    r = rd_q.pop_front();
                    chk(r.nm, bus.usr_data_rdata, r.v);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bus.usr_ctrl_vld = 0; bus.usr_ctrl_wnr = 0;
        bus.usr_data_addr = '0; bus.usr_data_cfgdata = '0;

        s = idle(); s.rst = 1;
        cyc(s); cyc(s);
        cyc(idle());
        rd_exp(5'd1, 8'h05, "status_after_reset");

        wr(5'd0, 8'h17);
        chk("plan_txen", txen, 1); chk("plan_parity", parity_cfg, 2'b01); chk("plan_stop", stop_cfg, 1);
        rd_exp(5'd0, 8'h17, "ctrl_readback");
        wr(5'd5, 8'h48);
        chk("plan_baud", baud_cmp, 8'h48);

        for (int i = 1; i <= 9; i++) wr(5'd6, 8'(i));
        chk("plan_tx_full", txf, 1);
        rd_exp(5'd8, 8'd8, "tx_level_full");
        rd_exp(5'd1, 8'h29, "status_tx_ovf");
        for (int i = 1; i <= 8; i++) begin
            chk("plan_head_seq", tx_head, i);
            s = idle(); s.tx_pop = 1; cyc(s);
        end
        chk("plan_tx_empty", txe, 1);
        rd_exp(5'd1, 8'h05, "status_ovf_cleared");

        s = idle(); s.rx_push = 1; s.rxd = 8'hA5; cyc(s);
        s.rxd = 8'h3C; cyc(s);
        rd_exp(5'd9, 8'd2, "rx_level_two");
        rd_exp(5'd7, 8'hA5, "rxdata_first");
        rd_exp(5'd7, 8'h3C, "rxdata_second");
        chk("plan_rx_empty", rxe, 1);

        wr(5'd6, 8'h11);
        wr(5'd6, 8'h22, 1'b1);
        rd_exp(5'd8, 8'd1, "tx_level_push_pop");
        chk("plan_head_after_pp", tx_head, 8'h22);
        wr(5'd6, 8'h33, 1'b0, 1'b1);
        rd_exp(5'd8, 8'd0, "tx_level_flush");
        wr(5'd6, 8'h44, 1'b1);
        rd_exp(5'd8, 8'd1, "tx_level_push_pop_empty");
        for (int i = 0; i < 7; i++) wr(5'd6, 8'(8'h50 + i));
        wr(5'd6, 8'h60, 1'b1);
        rd_exp(5'd1, 8'h09, "status_full_push_pop");
        wr(5'd0, 8'h37);
        rd_exp(5'd0, 8'h17, "ctrl_flush_selfclear");
        rd_exp(5'd8, 8'd0, "tx_level_ctrl_flush");
        wr(5'd1, 8'hFF);
        rd_exp(5'd6, 8'h00, "txdata_reads_zero");
        rd_exp(5'd15, 8'h00, "unmapped_reads_zero");

        wr(5'd10, 8'h03);
        s = idle(); s.rx_push = 1;
        for (int i = 0; i < 3; i++) begin
            chk("plan_irq_low", irq, 0);
            s.rxd = 8'(8'h70 + i);
            cyc(s);
        end
        chk("plan_irq_high", irq, IRQ_EN);
        rd_exp(5'd7, 8'h70, "rxdata_irq");
        chk("plan_irq_fall", irq, 0);

        for (int i = 0; i < 500; i++) begin
            int v;
            s = idle();
            s.vld = ($urandom_range(0, 99) < 60);
            s.wnr = 1'($urandom_range(0, 1));
            v = $urandom_range(0, 99);
            s.addr = (v < 30) ? 5'd6 : (v < 45) ? 5'd7 : 5'($urandom_range(0, 11));
            s.wd = 8'($urandom);
            if (s.addr == 5'd0 && $urandom_range(0, 7) != 0) s.wd[6:5] = 2'b00;
            if (!s.wnr && s.addr == 5'd7 && m_rx.size() == 0) s.addr = 5'd9;
            s.tx_pop  = ($urandom_range(0, 99) < ((i < 250) ? 3 : 40));
            s.rx_push = ($urandom_range(0, 99) < ((i < 250) ? 30 : 10));
            s.rxd     = 8'($urandom);
            s.tx_rst  = ($urandom_range(0, 59) == 0);
            s.rx_rst  = ($urandom_range(0, 59) == 0);
            s.rst     = ($urandom_range(0, 249) == 0);
            cyc(s);
        end

        cyc(idle());
        cyc(idle());
        chk("scoreboard_drained", st_q.size() + rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cfg_regfile_fifo.md
# uart_cfg_regfile_fifo

Parametrised configuration/data register file for the UART protocol layer. It sits between the user bus and the Tx/Rx protocol state machines. It holds the link configuration registers (enable, parity mode, stop bits, addresses, stop frame, baud compare) and buffers transmit and receive bytes in two independent FIFOs of configurable width and depth. It supersedes the fixed 8-bit regfile: it adds a selectable parity mode, FIFO level readback, sticky overflow flags, a registered read-data path and self-clearing flush.

## Interface
- DATA_W, 8, width of data bytes and every config register
- FIFO_AW, 3, FIFO address bits; depth = 2**FIFO_AW
- ADDR_W, 5, user address width
- glb_clk  in  1  sole clock; all state changes on rising edge
- glb_rst  in  1  synchronous, active-high reset
- usr_ctrl_vld  in  1  user access strobe; one access per cycle when high
- usr_ctrl_wnr  in  1  1 = write, 0 = read (qualified by usr_ctrl_vld)
- usr_data_addr  in  ADDR_W  register address
- usr_data_cfgdata  in  DATA_W  write data
- usr_data_rdata  out  DATA_W  registered read data
- PROT_CFG_ctrl_tx_r_en  in  1  Tx FSM pops Tx FIFO head
- PROT_CFG_ctrl_tx_rst  in  1  Tx FSM flushes Tx FIFO
- PROT_CFG_ctrl_rx_w_en  in  1  Rx FSM pushes PROT_CFG_data_rx_data
- PROT_CFG_ctrl_rx_rst  in  1  Rx FSM flushes Rx FIFO
- PROT_CFG_data_rx_data  in  DATA_W  received byte
- CFG_SEL_data_tx_data  out  DATA_W  Tx FIFO head (show-ahead)
- Tx_FIFO_full, Tx_FIFO_empty, Rx_FIFO_full, Rx_FIFO_empty  out  1 each  FIFO flags
- parity_cfg  out  2  00 none, 01 even, 10 odd, 11 = none
- stop_cfg  out  1  0 = 1 stop bit, 1 = 2 stop bits
- CFG_PROT_ctrl_Txen, CFG_PROT_ctrl_Rxen  out  1 each  Tx/Rx enables
- slave_addr, self_addr, stop_frame, baud_cmp  out  DATA_W each  config registers
- CFG_irq  out  1  interrupt (only with UART_CFG_IRQ_EN)

## Operation
- Register map:
  - 0 CTRL RW: [0] Txen, [1] Rxen, [3:2] parity, [4] stop, [5] Tx flush, [6] Rx flush. Bits 5–6 self-clear and read 0.
  - 1 STATUS RO: [0] Rx_empty, [1] Rx_full, [2] Tx_empty, [3] Tx_full, [4] rx_ovf, [5] tx_ovf.
  - 2 SLAVE_ADDR, 3 SELF_ADDR, 4 STOP_FRAME, 5 BAUD_CMP: RW.
  - 6 TXDATA: WO, pushes into the Tx FIFO.
  - 7 RXDATA: RO, pops the Rx FIFO.
  - 8 TX_LEVEL, 9 RX_LEVEL: RO occupancy, 0..2**FIFO_AW, zero-extended to DATA_W.
  - 10 IRQ_CFG: RW, only with the macro.
  - Other addresses: writes ignored, reads return 0.
- A write to any RO address is ignored.
- A read of TXDATA returns 0.
- FIFOs are circular buffers with (FIFO_AW+1)-bit pointers.
  - full when pointers differ only in the MSB; empty when equal.
  - Pointers wrap naturally.
- Push while full: data dropped, pointers unchanged, sticky ovf flag set (tx_ovf from user, rx_ovf from Rx FSM).
- Pop while empty: ignored; head output unchanged.
- Simultaneous push and pop while non-empty: both take effect and the level is unchanged.
- Simultaneous push and pop while empty: the push succeeds and the pop is ignored.
- Simultaneous push and pop while full: the pop succeeds and the push is accepted, so no overflow.
- Flush (CTRL bit or *_rst input) zeroes both pointers. Flush beats a same-cycle push or pop. Flush does not clear the ovf flags.
- Reading STATUS clears both ovf flags after capture. A same-cycle new overflow wins, and the flag stays set.
- glb_rst: all registers, pointers, flags and usr_data_rdata go to 0. FIFO memory contents are not reset.

## Timing
- Config writes are visible on the outputs the cycle after the write edge.
- Read latency is 1 cycle: usr_data_rdata is valid the cycle after vld & ~wnr. It holds its value until the next read.
- RXDATA read: usr_data_rdata = old head; the pointer advances on the same edge.
- A TXDATA push makes Tx_FIFO_empty fall one cycle after the edge. CFG_SEL_data_tx_data tracks the head combinationally from the read pointer.
- Reset applied mid-operation takes effect on the next edge and discards any in-flight access.

## Configuration
- UART_CFG_IRQ_EN defined:
  - IRQ_CFG[FIFO_AW:0] = Rx threshold; IRQ_CFG[7] = ovf interrupt enable.
  - CFG_irq is a registered output, high when RX_LEVEL ≥ threshold (threshold ≠ 0) or when (ovf enable & any ovf flag).
- Undefined: address 10 reads 0 and ignores writes; CFG_irq is tied to 0.

## Test plan
- Reset: assert glb_rst 2 cycles -> all outputs 0, both FIFOs empty, STATUS reads 8'h05.
- Config: write CTRL=8'b0001_0111 -> Txen=1, Rxen=1, parity_cfg=01, stop_cfg=1. Read CTRL -> 8'h17. Write BAUD_CMP=8'h48 -> baud_cmp=8'h48 next cycle.
- Tx fill/overflow (FIFO_AW=3): push 1..9 into TXDATA -> full after 8 pushes, tx_ovf=1, TX_LEVEL=8. Pop 8 -> head sequence 1..8, then empty. STATUS read returns bit5=1; the next STATUS read returns bit5=0.
- Rx path: Rx FSM pushes 8'hA5, 8'h3C -> RX_LEVEL=2. Read RXDATA twice -> rdata A5 then 3C, Rx_empty=1.
- Simultaneous and flush: with 1 entry in the Tx FIFO, push and pop in the same cycle -> level stays 1. Assert PROT_CFG_ctrl_tx_rst together with a push -> level 0, empty.
- UART_CFG_IRQ_EN: IRQ_CFG=8'h03, then 3 Rx pushes -> CFG_irq rises the cycle after the third push. Read RXDATA once -> CFG_irq falls.
